// File: rtl/status_frame_writer_if.sv
// BRAM write port shared between the status frame writer and the PC-visible memory.
interface status_frame_writer_if;
    logic [12:0] bram_addr;
    logic [15:0] bram_din;
    logic        bram_we;

    modport master (output bram_addr, output bram_din, output bram_we);
    modport slave  (input  bram_addr, input  bram_din, input  bram_we);
endinterface

// File: rtl/status_frame_writer.sv
// Publishes an 11-word status frame (magic, seq, 8 live words, checksum) into BRAM
// on a trigger edge and holds frame_rdy until the PC acknowledges it.
module status_frame_writer #(
    parameter logic [12:0] BASE_ADDR = 13'd0,
    parameter logic [15:0] MAGIC     = 16'hA55A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    input  logic        pc_ack,
    input  logic [15:0] xdata_points_number,
    input  logic [15:0] xdata_block_number,
    input  logic [15:0] ydata_points_number,
    input  logic [15:0] cycles_per_points,
    input  logic [15:0] da_delay_cycles,
    input  logic [15:0] acq_delay_cycles,
    input  logic [15:0] ccd_delay_cycles,
    input  logic [15:0] system_state,
    status_frame_writer_if.master bram,
    output logic        frame_rdy,
    output logic        busy,
    output logic [15:0] seq_num,
    output logic [7:0]  drop_cnt
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LATCH   = 3'd1;
    localparam logic [2:0] WRITE   = 3'd2;
    localparam logic [2:0] CHECK   = 3'd3;
    localparam logic [2:0] PUBLISH = 3'd4;

    logic [2:0]       state;
    logic             trig_d0, trig_d1, ack_d0, ack_d1;
    logic             trig_edge, ack_edge;
    logic [9:0][15:0] words;
    logic [15:0]      sum;
    logic [3:0]       k;

    always_comb begin
        trig_edge = trig_d0 & ~trig_d1;
        ack_edge  = ack_d0 & ~ack_d1;
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            trig_d0        <= 1'b0;
            trig_d1        <= 1'b0;
            ack_d0         <= 1'b0;
            ack_d1         <= 1'b0;
            words          <= '0;
            sum            <= '0;
            k              <= '0;
            bram.bram_we   <= 1'b0;
            bram.bram_addr <= '0;
            bram.bram_din  <= '0;
            frame_rdy      <= 1'b0;
            seq_num        <= '0;
            drop_cnt       <= '0;
        end else begin
            trig_d0 <= trigger;
            trig_d1 <= trig_d0;
            ack_d0  <= pc_ack;
            ack_d1  <= ack_d0;

            if (trig_edge && state != IDLE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (trig_edge)
                        state <= LATCH;
                end
                LATCH: begin
                    words <= {system_state, ccd_delay_cycles, acq_delay_cycles,
                              da_delay_cycles, cycles_per_points, ydata_points_number,
                              xdata_block_number, xdata_points_number, seq_num, MAGIC};
                    // Word 0 is constant, so it is issued here alongside the snapshot;
                    // WRITE then continues from word 1 with the sum already seeded.
                    bram.bram_we   <= 1'b1;
                    bram.bram_addr <= BASE_ADDR;
                    bram.bram_din  <= MAGIC;
                    sum            <= MAGIC;
                    k              <= 4'd1;
                    state          <= WRITE;
                end
                WRITE: begin
                    bram.bram_we   <= 1'b1;
                    bram.bram_addr <= BASE_ADDR + {8'd0, k, 1'b0};
                    bram.bram_din  <= words[k];
                    sum            <= sum + words[k];
                    if (k == 4'd9)
                        state <= CHECK;
                    else
                        k <= k + 4'd1;
                end
                CHECK: begin
                    bram.bram_we   <= 1'b1;
                    bram.bram_addr <= BASE_ADDR + 13'd20;
                    bram.bram_din  <= 16'h0000 - sum;
                    state          <= PUBLISH;
                end
                PUBLISH: begin
                    bram.bram_we <= 1'b0;
                    if (ack_edge) begin
                        frame_rdy <= 1'b0;
                        seq_num   <= seq_num + 16'd1;
                        state     <= IDLE;
                    end else begin
                        frame_rdy <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_status_frame_writer.sv
// Randomised self-checking bench for status_frame_writer against a frame-level model.
module tb_status_frame_writer;

    typedef logic [15:0] vals_t [8];
    typedef logic [15:0] frame_t [11];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic trigger = 1'b0;
    logic pc_ack = 1'b0;
    vals_t in_w;
    logic frame_rdy, busy;
    logic [15:0] seq_num;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_seq = 16'd0;
    int exp_drop = 0;

    logic [12:0] cap_addr [$];
    logic [15:0] cap_din [$];

    status_frame_writer_if bram_bus ();

    status_frame_writer #(.BASE_ADDR(13'd0), .MAGIC(16'hA55A)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .trigger             (trigger),
        .pc_ack              (pc_ack),
        .xdata_points_number (in_w[0]),
        .xdata_block_number  (in_w[1]),
        .ydata_points_number (in_w[2]),
        .cycles_per_points   (in_w[3]),
        .da_delay_cycles     (in_w[4]),
        .acq_delay_cycles    (in_w[5]),
        .ccd_delay_cycles    (in_w[6]),
        .system_state        (in_w[7]),
        .bram                (bram_bus),
        .frame_rdy           (frame_rdy),
        .busy                (busy),
        .seq_num             (seq_num),
        .drop_cnt            (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bram_bus.bram_we === 1'b1) begin
            cap_addr.push_back(bram_bus.bram_addr);
            cap_din.push_back(bram_bus.bram_din);
        end
    end

    function automatic void model_frame(input logic [15:0] seq, input vals_t v, output frame_t w);
        logic [15:0] s;
        w[0] = 16'hA55A;
        w[1] = seq;
        for (int i = 0; i < 8; i++) w[i + 2] = v[i];
        s = 16'h0000;
        for (int i = 0; i < 10; i++) s = s + w[i];
        w[10] = 16'h0000 - s;
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < 8; i++) in_w[i] = 16'($urandom);
    endtask

    // Pulses (or holds) trigger and waits for frame_rdy; cycle numbers count negedges after trigger rises.
    task automatic run_frame(input int change_at, input bit hold,
                             output int first_we, output int rdy_at, output bit timed_out);
        int n;
        cap_addr.delete();
        cap_din.delete();
        first_we = -1;
        rdy_at = -1;
        n = 0;
        @(negedge clk);
        trigger = 1'b1;
        while (rdy_at < 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (!hold && n == 1) trigger = 1'b0;
            if (n == change_at) for (int i = 0; i < 8; i++) in_w[i] = 16'hFFFF;
            if (first_we < 0 && bram_bus.bram_we === 1'b1) first_we = n;
            if (rdy_at < 0 && frame_rdy === 1'b1) rdy_at = n;
        end
        timed_out = (rdy_at < 0);
    endtask

    task automatic ack_frame();
        @(negedge clk);
        pc_ack = 1'b1;
        repeat (2) @(negedge clk);
        pc_ack = 1'b0;
        exp_seq = exp_seq + 16'd1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({frame_rdy, busy, bram_bus.bram_we} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got rdy/busy/we=%b expected 000", {frame_rdy, busy, bram_bus.bram_we});
        end
        checks++;
        if (seq_num !== 16'd0 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_counters: got seq=%h drop=%0d expected 0/0", seq_num, drop_cnt);
        end
        checks++;
        if (bram_bus.bram_addr !== 13'd0 || bram_bus.bram_din !== 16'd0) begin
            errors++; $display("FAIL reset_bus: got addr=%h din=%h expected 0/0", bram_bus.bram_addr, bram_bus.bram_din);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        int first_we, rdy_at;
        bit to;
        frame_t exp;
        logic [15:0] total;
        in_w = '{16'h0100, 16'h0004, 16'h0200, 16'h00C8, 16'h000A, 16'h0014, 16'h001E, 16'h0003};
        model_frame(exp_seq, in_w, exp);
        run_frame(-1, 1'b0, first_we, rdy_at, to);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout: frame_rdy never rose within 60 cycles"); end
        checks++;
        if (first_we != 3) begin errors++; $display("FAIL basic_first_we: got cycle %0d expected 3", first_we); end
        checks++;
        if (rdy_at != 14) begin errors++; $display("FAIL basic_rdy_time: got cycle %0d expected 14", rdy_at); end
        checks++;
        if (cap_din.size() != 11) begin errors++; $display("FAIL basic_write_count: got %0d expected 11", cap_din.size()); end
        total = 16'h0000;
        for (int k = 0; k < 11 && k < cap_din.size(); k++) begin
            total = total + cap_din[k];
            checks++;
            if (cap_addr[k] !== 13'(2 * k) || cap_din[k] !== exp[k]) begin
                errors++; $display("FAIL basic_word%0d: got addr=%h data=%h expected addr=%h data=%h",
                                   k, cap_addr[k], cap_din[k], 13'(2 * k), exp[k]);
            end
        end
        checks++;
        if (cap_din.size() != 11 || cap_din[10] !== 16'h569B) begin
            errors++; $display("FAIL basic_checksum: got %h expected 569b", cap_din.size() == 11 ? cap_din[10] : 16'hxxxx);
        end
        checks++;
        if (total !== 16'h0000) begin errors++; $display("FAIL basic_total_sum: got %h expected 0000", total); end
    endtask

    task automatic test_ack_seq();
        int low_cycles;
        int first_we, rdy_at;
        bit to;
        frame_t exp;
        low_cycles = 0;
        repeat (100) begin
            @(negedge clk);
            if (frame_rdy !== 1'b1 || busy !== 1'b1) low_cycles++;
        end
        checks++;
        if (low_cycles != 0) begin errors++; $display("FAIL publish_hold: frame_rdy/busy low for %0d of 100 cycles, expected 0", low_cycles); end
        pc_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_rdy !== 1'b1) begin errors++; $display("FAIL ack_one_edge: got frame_rdy=%b expected 1", frame_rdy); end
        @(negedge clk);
        checks++;
        if (frame_rdy !== 1'b0 || busy !== 1'b0 || seq_num !== 16'd1) begin
            errors++; $display("FAIL ack_two_edges: got rdy=%b busy=%b seq=%h expected 0 0 0001", frame_rdy, busy, seq_num);
        end
        pc_ack = 1'b0;
        exp_seq = 16'd1;
        @(negedge clk);
        randomize_inputs();
        model_frame(exp_seq, in_w, exp);
        run_frame(-1, 1'b0, first_we, rdy_at, to);
        checks++;
        if (to || cap_din.size() != 11) begin
            errors++; $display("FAIL second_frame_shape: timeout=%0d writes=%0d expected 0/11", to, cap_din.size());
        end
        for (int k = 0; k < 11 && k < cap_din.size(); k++) begin
            checks++;
            if (cap_din[k] !== exp[k]) begin errors++; $display("FAIL second_word%0d: got %h expected %h", k, cap_din[k], exp[k]); end
        end
        ack_frame();
    endtask

    task automatic test_snapshot();
        int first_we, rdy_at;
        bit to;
        frame_t exp;
        logic [15:0] total;
        randomize_inputs();
        model_frame(exp_seq, in_w, exp);
        run_frame(5, 1'b0, first_we, rdy_at, to);
        checks++;
        if (to || cap_din.size() != 11) begin
            errors++; $display("FAIL snapshot_shape: timeout=%0d writes=%0d expected 0/11", to, cap_din.size());
        end
        total = 16'h0000;
        for (int k = 0; k < 11 && k < cap_din.size(); k++) begin
            total = total + cap_din[k];
            checks++;
            if (cap_din[k] !== exp[k]) begin errors++; $display("FAIL snapshot_word%0d: got %h expected %h", k, cap_din[k], exp[k]); end
        end
        checks++;
        if (total !== 16'h0000) begin errors++; $display("FAIL snapshot_total_sum: got %h expected 0000", total); end
        ack_frame();
    endtask

    task automatic test_drops();
        int n;
        randomize_inputs();
        cap_addr.delete();
        cap_din.delete();
        @(negedge clk);
        trigger = 1'b1;
        n = 0;
        while (frame_rdy !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
            trigger = (n == 4);
        end
        exp_drop = 1;
        repeat (2) begin
            @(negedge clk); trigger = 1'b1;
            @(negedge clk); trigger = 1'b0;
        end
        exp_drop = 3;
        repeat (4) @(negedge clk);
        checks++;
        if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL drop_three: got %0d expected %0d", drop_cnt, exp_drop); end
        checks++;
        if (cap_din.size() != 11 || frame_rdy !== 1'b1) begin
            errors++; $display("FAIL drop_no_extra: writes=%0d rdy=%b expected 11/1", cap_din.size(), frame_rdy);
        end
        repeat (300) begin
            @(negedge clk); trigger = 1'b1;
            @(negedge clk); trigger = 1'b0;
        end
        exp_drop = (3 + 300 > 255) ? 255 : 3 + 300;
        repeat (4) @(negedge clk);
        checks++;
        if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL drop_saturate: got %0d expected %0d", drop_cnt, exp_drop); end
        checks++;
        if (cap_din.size() != 11) begin errors++; $display("FAIL drop_saturate_writes: got %0d expected 11", cap_din.size()); end
        ack_frame();
    endtask

    task automatic test_held_trigger();
        int first_we, rdy_at;
        bit to;
        randomize_inputs();
        run_frame(-1, 1'b1, first_we, rdy_at, to);
        ack_frame();
        cap_addr.delete();
        cap_din.delete();
        repeat (20) @(negedge clk);
        checks++;
        if (to || cap_din.size() != 0 || busy !== 1'b0 || drop_cnt !== 8'(exp_drop)) begin
            errors++; $display("FAIL held_trigger: timeout=%0d extra_writes=%0d busy=%b drop=%0d expected 0/0/0/%0d",
                               to, cap_din.size(), busy, drop_cnt, exp_drop);
        end
        trigger = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ack_idle();
        cap_addr.delete();
        cap_din.delete();
        @(negedge clk); pc_ack = 1'b1;
        @(negedge clk); pc_ack = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (seq_num !== exp_seq || busy !== 1'b0 || frame_rdy !== 1'b0 || cap_din.size() != 0) begin
            errors++; $display("FAIL ack_in_idle: seq=%h busy=%b rdy=%b writes=%0d expected %h 0 0 0",
                               seq_num, busy, frame_rdy, cap_din.size(), exp_seq);
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        int first_we, rdy_at;
        bit to;
        frame_t exp;
        randomize_inputs();
        @(negedge clk);
        trigger = 1'b1;
        n = 0;
        while (!(bram_bus.bram_we === 1'b1 && bram_bus.bram_addr === 13'd10) && n < 60) begin
            @(negedge clk);
            n++;
            trigger = 1'b0;
        end
        checks++;
        if (n >= 60) begin errors++; $display("FAIL midframe_reach_word5: word 5 write not seen within 60 cycles"); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bram_bus.bram_we, frame_rdy, busy} !== 3'b000 || seq_num !== 16'd0 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL midframe_reset: we/rdy/busy=%b seq=%h drop=%0d expected 000 0000 0",
                               {bram_bus.bram_we, frame_rdy, busy}, seq_num, drop_cnt);
        end
        exp_seq = 16'd0;
        exp_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        randomize_inputs();
        model_frame(exp_seq, in_w, exp);
        run_frame(-1, 1'b0, first_we, rdy_at, to);
        checks++;
        if (to || cap_din.size() != 11 || cap_addr[0] !== 13'd0) begin
            errors++; $display("FAIL restart_shape: timeout=%0d writes=%0d first_addr=%h expected 0/11/0000",
                               to, cap_din.size(), cap_addr.size() > 0 ? cap_addr[0] : 13'h1fff);
        end
        for (int k = 0; k < 11 && k < cap_din.size(); k++) begin
            checks++;
            if (cap_din[k] !== exp[k]) begin errors++; $display("FAIL restart_word%0d: got %h expected %h", k, cap_din[k], exp[k]); end
        end
        ack_frame();
    endtask

    task automatic test_seq_wrap();
        int first_we, rdy_at;
        bit to;
        frame_t exp;
        @(negedge clk);
        force dut.seq_num = 16'hFFFF;
        @(negedge clk);
        release dut.seq_num;
        exp_seq = 16'hFFFF;
        randomize_inputs();
        model_frame(exp_seq, in_w, exp);
        run_frame(-1, 1'b0, first_we, rdy_at, to);
        checks++;
        if (to || cap_din.size() != 11 || cap_din[1] !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_frame: timeout=%0d writes=%0d word1=%h expected 0/11/ffff",
                               to, cap_din.size(), cap_din.size() > 1 ? cap_din[1] : 16'hxxxx);
        end
        for (int k = 0; k < 11 && k < cap_din.size(); k++) begin
            checks++;
            if (cap_din[k] !== exp[k]) begin errors++; $display("FAIL wrap_word%0d: got %h expected %h", k, cap_din[k], exp[k]); end
        end
        ack_frame();
        checks++;
        if (seq_num !== exp_seq || exp_seq !== 16'h0000) begin
            errors++; $display("FAIL wrap_seq: got %h expected 0000", seq_num);
        end
    endtask

    task automatic test_random_frames();
        int first_we, rdy_at;
        bit to;
        frame_t exp;
        logic [15:0] total;
        for (int f = 0; f < 4; f++) begin
            randomize_inputs();
            model_frame(exp_seq, in_w, exp);
            run_frame(-1, 1'b0, first_we, rdy_at, to);
            checks++;
            if (to || first_we != 3 || rdy_at != 14 || cap_din.size() != 11) begin
                errors++; $display("FAIL rand%0d_shape: timeout=%0d first_we=%0d rdy_at=%0d writes=%0d expected 0/3/14/11",
                                   f, to, first_we, rdy_at, cap_din.size());
            end
            total = 16'h0000;
            for (int k = 0; k < 11 && k < cap_din.size(); k++) begin
                total = total + cap_din[k];
                checks++;
                if (cap_addr[k] !== 13'(2 * k) || cap_din[k] !== exp[k]) begin
                    errors++; $display("FAIL rand%0d_word%0d: got addr=%h data=%h expected addr=%h data=%h",
                                       f, k, cap_addr[k], cap_din[k], 13'(2 * k), exp[k]);
                end
            end
            checks++;
            if (total !== 16'h0000) begin errors++; $display("FAIL rand%0d_total_sum: got %h expected 0000", f, total); end
            ack_frame();
            checks++;
            if (seq_num !== exp_seq) begin errors++; $display("FAIL rand%0d_seq: got %h expected %h", f, seq_num, exp_seq); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) in_w[i] = 16'h0000;
        test_reset();
        test_basic_frame();
        test_ack_seq();
        test_snapshot();
        test_drops();
        test_held_trigger();
        test_ack_idle();
        test_reset_midframe();
        test_seq_wrap();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
